fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue sitting between the program counter / InstMem fetch stage and the decode stage of the RISC-V core. It captures each fetched `{pc, Inst}` pair into a small circular FIFO and presents them to decode through a valid/ready handshake, decoupling fetch from decode stalls. A synchronous flush discards every queued entry when a taken branch redirects the PC.

## Interface
Parameters:
- `XLEN`, 32, width of PC and instruction words
- `DEPTH`, 4, number of entries; power of two, ≥ 2

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  discard all entries (taken branch / redirect)
- `in_valid`  in  1  fetch stage presents a valid pair
- `in_pc`  in  XLEN  PC of fetched instruction
- `in_inst`  in  XLEN  instruction word from InstMem
- `in_ready`  out  1  queue accepts a pair this cycle
- `out_valid`  out  1  head entry valid for decode
- `out_pc`  out  XLEN  PC of head entry
- `out_inst`  out  XLEN  instruction of head entry
- `out_ready`  in  1  decode consumes the head this cycle
- `count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: `DEPTH` entries of `{pc, inst}`; write pointer, read pointer, and occupancy counter. Pointers are `$clog2(DEPTH)` bits and wrap from `DEPTH-1` to 0.
- Push: `in_valid && in_ready` on a rising edge writes at the write pointer and advances it.
- Pop: `out_valid && out_ready` on a rising edge advances the read pointer.
- Push and pop in the same cycle leave `count` unchanged. Data is written and read correctly, including when pointers wrap.
- `in_ready = !rst && !flush && (count != DEPTH)`. It does not depend on `out_ready`, so a full queue rejects a push even in a cycle where it pops.
- `out_valid = !flush && (count != 0)`. `out_pc`/`out_inst` always show the entry at the read pointer.
- Flush: while `flush` is high, no push or pop is accepted. At the edge, both pointers and `count` go to 0. Entry contents are not cleared. A flush asserted with `count == 0` has no effect.
- Reset (asynchronous, any time, including mid-push/pop): pointers = 0, `count` = 0, `out_valid` = 0, `in_ready` = 0 while `rst` is high. Storage contents are undefined and never observable.
- `count` is registered and never exceeds `DEPTH`. Underflow and overflow are impossible by construction of `in_ready`/`out_valid`.

## Timing
- Latency without bypass: a pair pushed at edge N appears with `out_valid = 1` in the cycle after edge N.
- Throughput: one push and one pop per cycle sustained.
- `in_ready` and `out_valid` are combinational from registered state plus `rst`/`flush` only. There is no `out_ready`→`in_ready` path.
- `in_ready` goes to 1 in the first cycle after `rst` deasserts.

## Configuration
- `FETCH_Q_BYPASS_EN` defined:
  - When `count == 0 && in_valid && !flush`, the outputs are driven combinationally: `out_valid = 1`, `out_pc = in_pc`, `out_inst = in_inst`.
  - If `out_ready` is also 1, the pair is consumed in that cycle and is not stored (zero latency, `count` stays 0).
  - If `out_ready` is 0, the pair is stored normally.
- Not defined: no combinational input→output path. Minimum latency is 1 cycle as stated under Timing.

## Test plan
- Reset mid-stream: push 2 entries, assert `rst` asynchronously between edges → `count` = 0, `out_valid` = 0, and `in_ready` = 0 immediately. After release, `in_ready` = 1 and `out_valid` = 0.
- Fill and drain with `DEPTH = 4`: push PCs 0x0, 0x4, 0x8, 0xC with `out_ready = 0` → `count` = 4, `in_ready` = 0. A fifth push (0x10) is refused. Raise `out_ready` → heads 0x0, 0x4, 0x8, 0xC appear in order, then `out_valid` = 0.
- Wrap-around: push and pop simultaneously for 10 cycles with PCs 0x0 through 0x24 → output sequence matches the input sequence exactly and `count` stays constant.
- Flush: queue holds 3 entries, assert `flush` together with `in_valid` (PC 0x40) → at the next edge `count` = 0, PC 0x40 is dropped, and `out_valid` = 0. The next push of PC 0x8 (branch target) is the next head.
- Full plus pop: `count` = 4, `in_valid` = 1, `out_ready` = 1 → pop occurs, push refused, `count` = 3.
- Bypass (`FETCH_Q_BYPASS_EN`): empty queue, `in_valid` = 1, `in_pc` = 0x100, `out_ready` = 1 → `out_valid` = 1 and `out_pc` = 0x100 in the same cycle, and `count` stays 0. Without the macro, the same stimulus shows `out_pc` = 0x100 one cycle later with `count` = 1 in between.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch queue between the PC/InstMem fetch stage and decode.
//   Each fetched {pc, inst} pair is captured into a DEPTH-entry circular
//   FIFO and handed to decode with a valid/ready handshake, so a decode
//   stall does not immediately stall fetch. A synchronous flush (taken
//   branch / redirect) drops every queued entry.
//
// Parameters
//   XLEN   width of PC and instruction words
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   flush                 discard all entries at the next edge
//   in_valid/in_ready     fetch-side handshake, carries in_pc/in_inst
//   out_valid/out_ready   decode-side handshake, carries out_pc/out_inst
//   count                 occupied entries (registered)
//
// Configuration
//   FETCH_Q_BYPASS_EN     when defined, an empty queue forwards the incoming
//                         pair to decode combinationally; if decode takes it
//                         in the same cycle it is never stored.

module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            q_valid;
    logic            byp;
    logic            push;
    logic            pop;
    logic            store;
    logic            q_pop;

    assign q_valid  = (count != '0);

    // in_ready comes from registered state plus rst/flush only; it must not
    // see out_ready, so a full queue refuses a push even while it pops.
    assign in_ready = !rst && !flush && (count != FULL);

`ifdef FETCH_Q_BYPASS_EN
    // Empty queue: show the incoming pair straight to decode. rst is included
    // so out_valid stays low throughout reset.
    assign byp = !rst && !flush && in_valid && !q_valid;
`else
    assign byp = 1'b0;
`endif

    assign out_valid = !flush && (q_valid || byp);
    assign out_pc    = byp ? in_pc   : mem[rd_ptr].pc;
    assign out_inst  = byp ? in_inst : mem[rd_ptr].inst;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    // A bypassed pair taken by decode this cycle is consumed, not stored;
    // a queue pop only happens when the head came from storage.
    assign store = push && !(byp && pop);
    assign q_pop = pop && !byp;

    // Storage has no reset: its contents are only observable behind count.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr].pc   <= in_pc;
            mem[wr_ptr].inst <= in_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (q_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({store, q_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_ready;
    logic [CW-1:0]   count;

    int total = 0;
    int pass  = 0;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] pc);
        return pc ^ 32'h1300_0013;
    endfunction

    // Advance one edge; inputs change and checks happen 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        out_ready = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        #2;
        total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else pass++;
        tick();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL release_out_valid got %b want 0", out_valid); else pass++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h0, 1'b0); tick();
        drive(1'b1, 32'h4, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0);
        total++; if (count !== 3'd2) $display("FAIL mid_pre_count got %0d want 2", count); else pass++;
        #2 rst = 1'b1;
        #1;
        total++; if (count !== 3'd0) $display("FAIL mid_rst_count got %0d want 0", count); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got %b want 0", out_valid); else pass++;
        total++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got %b want 0", in_ready); else pass++;
        tick();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_release_in_ready got %b want 1", in_ready); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_release_out_valid got %b want 0", out_valid); else pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0);
            tick();
        end
        total++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else pass++;
        total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b want 0", in_ready); else pass++;
        drive(1'b1, 32'h10, 1'b0);
        tick();
        total++; if (count !== 3'd4) $display("FAIL fifth_push_count got %0d want 4", count); else pass++;
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (out_valid !== 1'b1) $display("FAIL drain_valid[%0d] got %b want 1", i, out_valid); else pass++;
            total++; if (out_pc !== 32'(i * 4)) $display("FAIL drain_pc[%0d] got %h want %h", i, out_pc, 32'(i * 4)); else pass++;
            total++; if (out_inst !== inst_of(32'(i * 4))) $display("FAIL drain_inst[%0d] got %h want %h", i, out_inst, inst_of(32'(i * 4))); else pass++;
            tick();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL drain_empty_valid got %b want 0", out_valid); else pass++;
        total++; if (count !== 3'd0) $display("FAIL drain_empty_count got %0d want 0", count); else pass++;
        drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        // Prime one entry so every cycle after pushes and pops together.
        drive(1'b1, 32'h0, 1'b0);
        tick();
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1);
            #1;
            total++; if (out_pc !== 32'((i - 1) * 4)) $display("FAIL wrap_pc[%0d] got %h want %h", i, out_pc, 32'((i - 1) * 4)); else pass++;
            total++; if (count !== 3'd1) $display("FAIL wrap_count[%0d] got %0d want 1", i, count); else pass++;
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        #1;
        total++; if (out_pc !== 32'h24) $display("FAIL wrap_last_pc got %h want 24", out_pc); else pass++;
        total++; if (out_inst !== inst_of(32'h24)) $display("FAIL wrap_last_inst got %h want %h", out_inst, inst_of(32'h24)); else pass++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL wrap_empty_valid got %b want 0", out_valid); else pass++;
        drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h10 + 32'(i * 4), 1'b0);
            tick();
        end
        total++; if (count !== 3'd3) $display("FAIL flush_pre_count got %0d want 3", count); else pass++;
        flush = 1'b1;
        drive(1'b1, 32'h40, 1'b1);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else pass++;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #1;
        total++; if (count !== 3'd0) $display("FAIL flush_count got %0d want 0", count); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_after_valid got %b want 0", out_valid); else pass++;
        drive(1'b1, 32'h8, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        #1;
        total++; if (out_pc !== 32'h8) $display("FAIL flush_target_pc got %h want 8", out_pc); else pass++;
        total++; if (count !== 3'd1) $display("FAIL flush_target_count got %0d want 1", count); else pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) $display("FAIL flush_target_pop_count got %0d want 0", count); else pass++;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h20 + 32'(i * 4), 1'b0);
            tick();
        end
        total++; if (count !== 3'd4) $display("FAIL fullpop_pre_count got %0d want 4", count); else pass++;
        drive(1'b1, 32'h30, 1'b1);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL fullpop_in_ready got %b want 0", in_ready); else pass++;
        tick();
        drive(1'b0, 32'h0, 1'b0);
        #1;
        total++; if (count !== 3'd3) $display("FAIL fullpop_count got %0d want 3", count); else pass++;
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            total++; if (out_pc !== 32'h20 + 32'(i * 4)) $display("FAIL fullpop_drain_pc[%0d] got %h want %h", i, out_pc, 32'h20 + 32'(i * 4)); else pass++;
            tick();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL fullpop_empty_valid got %b want 0", out_valid); else pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h100, 1'b1);
        #1;
`ifdef FETCH_Q_BYPASS_EN
        total++; if (out_valid !== 1'b1) $display("FAIL byp_valid got %b want 1", out_valid); else pass++;
        total++; if (out_pc !== 32'h100) $display("FAIL byp_pc got %h want 100", out_pc); else pass++;
        total++; if (out_inst !== inst_of(32'h100)) $display("FAIL byp_inst got %h want %h", out_inst, inst_of(32'h100)); else pass++;
        tick();
        drive(1'b0, 32'h0, 1'b0);
        #1;
        total++; if (count !== 3'd0) $display("FAIL byp_count got %0d want 0", count); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL byp_after_valid got %b want 0", out_valid); else pass++;
`else
        total++; if (out_valid !== 1'b0) $display("FAIL nobyp_valid got %b want 0", out_valid); else pass++;
        tick();
        drive(1'b0, 32'h0, 1'b1);
        #1;
        total++; if (count !== 3'd1) $display("FAIL nobyp_count got %0d want 1", count); else pass++;
        total++; if (out_valid !== 1'b1) $display("FAIL nobyp_late_valid got %b want 1", out_valid); else pass++;
        total++; if (out_pc !== 32'h100) $display("FAIL nobyp_late_pc got %h want 100", out_pc); else pass++;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) $display("FAIL nobyp_pop_count got %0d want 0", count); else pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_fill_drain();
        test_wrap();
        test_flush();
        test_full_pop();
        test_bypass();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
